// File: rtl/io_tile_param.sv
// -----------------------------------------------------------------------------
// io_tile_param
//   Parametrised IO tile for the fabric perimeter. Pad inputs are routed onto
//   interconnect tracks and interconnect tracks onto pad outputs through
//   per-output select muxes. Each routed output is either combinational or
//   registered, as chosen by a per-output register-mode bit. All routing state
//   is held in a serial configuration chain that daisy-chains tile to tile.
//
// Parameters
//   IO_PAIRS  pad lanes (width of data_from_io / data_to_io)
//   IC_WIDTH  interconnect tracks (width of data_from_ic / data_to_ic)
//
// Ports
//   clock          in   1         rising-edge clock
//   reset          in   1         synchronous, active-high
//   data_from_io   in   IO_PAIRS  pad inputs
//   data_to_io     out  IO_PAIRS  pad outputs
//   data_from_ic   in   IC_WIDTH  interconnect inputs
//   data_to_ic     out  IC_WIDTH  interconnect outputs
//   config_enable  in   1         shift-chain enable (also blanks the outputs)
//   config_in      in   1         serial config bit in
//   config_out     out  1         serial config bit out (chain MSB)
//
// Config chain layout, LSB upward:
//   ic selects (IC_WIDTH x SEL_IC), io selects (IO_PAIRS x SEL_IO),
//   ic register-mode bits (IC_WIDTH), io register-mode bits (IO_PAIRS).
//
// Build option
//   IO_TILE_SYNC_EN  when defined, data_from_io passes through a 2-flop
//                    synchroniser before the ic muxes. The io path and the
//                    config chain are the same in both builds.
// -----------------------------------------------------------------------------
module io_tile_param #(
    parameter int IO_PAIRS = 4,
    parameter int IC_WIDTH = 6
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [IO_PAIRS-1:0] data_from_io,
    output logic [IO_PAIRS-1:0] data_to_io,
    input  logic [IC_WIDTH-1:0] data_from_ic,
    output logic [IC_WIDTH-1:0] data_to_ic,
    input  logic                config_enable,
    input  logic                config_in,
    output logic                config_out
);

    localparam int SEL_IC      = (IO_PAIRS > 1) ? $clog2(IO_PAIRS) : 1;
    localparam int SEL_IO      = (IC_WIDTH > 1) ? $clog2(IC_WIDTH) : 1;
    localparam int IO_SEL_BASE = IC_WIDTH * SEL_IC;
    localparam int IC_REG_BASE = IO_SEL_BASE + IO_PAIRS * SEL_IO;
    localparam int IO_REG_BASE = IC_REG_BASE + IC_WIDTH;
    localparam int CFG_LEN     = IO_REG_BASE + IO_PAIRS;

    // ------------------------------------------------------------------
    // Configuration shift chain
    // ------------------------------------------------------------------
    logic [CFG_LEN-1:0] cfg_q;
    logic [CFG_LEN-1:0] cfg_d;

    always_comb begin
        cfg_d = cfg_q;
        if (config_enable) begin
            cfg_d = {cfg_q[CFG_LEN-2:0], config_in};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cfg_q <= '0;
        end else begin
            cfg_q <= cfg_d;
        end
    end

    // Held low during reset so a tile downstream never sees a stale MSB.
    assign config_out = reset ? 1'b0 : cfg_q[CFG_LEN-1];

    // ------------------------------------------------------------------
    // Pad input conditioning
    // ------------------------------------------------------------------
    logic [IO_PAIRS-1:0] pad_in;

`ifdef IO_TILE_SYNC_EN
    logic [IO_PAIRS-1:0] sync1_q;
    logic [IO_PAIRS-1:0] sync1_d;
    logic [IO_PAIRS-1:0] sync2_q;
    logic [IO_PAIRS-1:0] sync2_d;

    always_comb begin
        sync1_d = data_from_io;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign pad_in = sync2_q;
`else
    assign pad_in = data_from_io;
`endif

    // ------------------------------------------------------------------
    // Select muxes. A select at or beyond the input width routes a 0.
    // ------------------------------------------------------------------
    logic [IC_WIDTH-1:0] raw_ic;
    logic [IO_PAIRS-1:0] raw_io;

    genvar gi;
    generate
        for (gi = 0; gi < IC_WIDTH; gi++) begin : g_ic_mux
            logic [SEL_IC-1:0] sel;
            logic              raw;
            assign sel = cfg_q[SEL_IC*gi +: SEL_IC];
            always_comb begin
                raw = 1'b0;
                for (int k = 0; k < IO_PAIRS; k++) begin
                    if (int'(sel) == k) begin
                        raw = pad_in[k];
                    end
                end
            end
            assign raw_ic[gi] = raw;
        end

        for (gi = 0; gi < IO_PAIRS; gi++) begin : g_io_mux
            logic [SEL_IO-1:0] sel;
            logic              raw;
            assign sel = cfg_q[IO_SEL_BASE + SEL_IO*gi +: SEL_IO];
            always_comb begin
                raw = 1'b0;
                for (int k = 0; k < IC_WIDTH; k++) begin
                    if (int'(sel) == k) begin
                        raw = data_from_ic[k];
                    end
                end
            end
            assign raw_io[gi] = raw;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Output blanking and optional output registers.
    // Blanking before the flops makes registered outputs read 0 from the
    // edge after config_enable rises, and recover one edge after it drops.
    // ------------------------------------------------------------------
    logic                blank;
    logic [IC_WIDTH-1:0] ic_gated;
    logic [IO_PAIRS-1:0] io_gated;
    logic [IC_WIDTH-1:0] ic_out_q;
    logic [IC_WIDTH-1:0] ic_out_d;
    logic [IO_PAIRS-1:0] io_out_q;
    logic [IO_PAIRS-1:0] io_out_d;

    assign blank    = reset | config_enable;
    assign ic_gated = blank ? '0 : raw_ic;
    assign io_gated = blank ? '0 : raw_io;

    always_comb begin
        ic_out_d = ic_gated;
        io_out_d = io_gated;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ic_out_q <= '0;
            io_out_q <= '0;
        end else begin
            ic_out_q <= ic_out_d;
            io_out_q <= io_out_d;
        end
    end

    generate
        for (gi = 0; gi < IC_WIDTH; gi++) begin : g_ic_out
            assign data_to_ic[gi] = cfg_q[IC_REG_BASE + gi] ? ic_out_q[gi] : ic_gated[gi];
        end
        for (gi = 0; gi < IO_PAIRS; gi++) begin : g_io_out
            assign data_to_io[gi] = cfg_q[IO_REG_BASE + gi] ? io_out_q[gi] : io_gated[gi];
        end
    endgenerate

endmodule

// File: tb/tb_io_tile_param.sv
// -----------------------------------------------------------------------------
// tb_io_tile_param
//   Directed self-checking bench for io_tile_param at default parameters.
//   Two tiles are chained (a.config_out -> b.config_in); all routing checks
//   use tile a. Expected latencies on the pad->ic path depend on whether
//   IO_TILE_SYNC_EN is defined for the build.
// -----------------------------------------------------------------------------
module tb_io_tile_param;

    logic       clock;
    logic       reset;
    logic [3:0] data_from_io;
    logic [5:0] data_from_ic;
    logic       config_enable;
    logic       config_in;

    logic [3:0] a_to_io;
    logic [5:0] a_to_ic;
    logic       a_cfg_out;
    logic [3:0] b_to_io;
    logic [5:0] b_to_ic;
    logic       b_cfg_out;

    int checks;
    int failures;

    io_tile_param #(.IO_PAIRS(4), .IC_WIDTH(6)) u_dut_a (
        .clock         (clock),
        .reset         (reset),
        .data_from_io  (data_from_io),
        .data_to_io    (a_to_io),
        .data_from_ic  (data_from_ic),
        .data_to_ic    (a_to_ic),
        .config_enable (config_enable),
        .config_in     (config_in),
        .config_out    (a_cfg_out)
    );

    io_tile_param #(.IO_PAIRS(4), .IC_WIDTH(6)) u_dut_b (
        .clock         (clock),
        .reset         (reset),
        .data_from_io  (data_from_io),
        .data_to_io    (b_to_io),
        .data_from_ic  (data_from_ic),
        .data_to_ic    (b_to_ic),
        .config_enable (config_enable),
        .config_in     (a_cfg_out),
        .config_out    (b_cfg_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Shift a 34-bit word into tile a, MSB first so it lands in place.
    task automatic load_cfg(input logic [33:0] v);
        config_enable = 1'b1;
        for (int i = 33; i >= 0; i--) begin
            config_in = v[i];
            tick();
        end
        config_enable = 1'b0;
        config_in     = 1'b0;
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        config_enable = 1'b1;
        for (int c = 0; c < 2; c++) begin
            data_from_io = 4'($urandom);
            data_from_ic = 6'($urandom);
            config_in    = 1'b1;
            tick();
            checks++;
            if (a_to_io !== 4'b0000) begin
                failures++;
                $display("FAIL reset_to_io cycle=%0d got=%b exp=0000", c, a_to_io);
            end
            checks++;
            if (a_to_ic !== 6'b000000) begin
                failures++;
                $display("FAIL reset_to_ic cycle=%0d got=%b exp=000000", c, a_to_ic);
            end
            checks++;
            if (a_cfg_out !== 1'b0) begin
                failures++;
                $display("FAIL reset_cfg_out cycle=%0d got=%b exp=0", c, a_cfg_out);
            end
        end
        reset         = 1'b0;
        config_enable = 1'b0;
        config_in     = 1'b0;
        data_from_io  = 4'd0;
        data_from_ic  = 6'd0;
        tick();
        // Shift the chain out: every bit must be 0 (reset beat config_enable).
        config_enable = 1'b1;
        for (int i = 0; i < 34; i++) begin
            checks++;
            if (a_cfg_out !== 1'b0) begin
                failures++;
                $display("FAIL reset_readback bit=%0d got=%b exp=0", i, a_cfg_out);
            end
            tick();
        end
        config_enable = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_comb_ic();
        logic [33:0] v;
        v      = '0;
        v[1:0] = 2'd2;          // ic0 <- pad 2, everything else sel 0, comb
        data_from_io = 4'b0000;
        data_from_ic = 6'd0;
        load_cfg(v);
        tick();
        tick();
        data_from_io = 4'b0100;
`ifdef IO_TILE_SYNC_EN
        tick();
        checks++;
        if (a_to_ic !== 6'b000000) begin
            failures++;
            $display("FAIL sync_lat1_a got=%b exp=000000", a_to_ic);
        end
        tick();
`else
        #1;
`endif
        checks++;
        if (a_to_ic !== 6'b000001) begin
            failures++;
            $display("FAIL comb_ic_0100 got=%b exp=000001", a_to_ic);
        end
        data_from_io = 4'b1011;
`ifdef IO_TILE_SYNC_EN
        tick();
        checks++;
        if (a_to_ic !== 6'b000001) begin
            failures++;
            $display("FAIL sync_lat1_b got=%b exp=000001", a_to_ic);
        end
        tick();
`else
        #1;
`endif
        checks++;
        if (a_to_ic !== 6'b111110) begin
            failures++;
            $display("FAIL comb_ic_1011 got=%b exp=111110", a_to_ic);
        end
        $display("test_comb_ic done");
    endtask

    task automatic test_reg_io();
        logic [33:0] v;
        v        = '0;
        v[23:21] = 3'd5;        // io3 <- track 5
        v[33]    = 1'b1;        // io3 registered
        data_from_io = 4'b0000;
        data_from_ic = 6'h00;
        load_cfg(v);
        tick();
        checks++;
        if (a_to_io !== 4'b0000) begin
            failures++;
            $display("FAIL reg_io_idle got=%b exp=0000", a_to_io);
        end
        data_from_ic = 6'h20;
        #1;
        checks++;
        if (a_to_io !== 4'b0000) begin
            failures++;
            $display("FAIL reg_io_before_edge got=%b exp=0000", a_to_io);
        end
        tick();
        checks++;
        if (a_to_io !== 4'b1000) begin
            failures++;
            $display("FAIL reg_io_after_edge got=%b exp=1000", a_to_io);
        end
        data_from_ic = 6'h00;
        #1;
        checks++;
        if (a_to_io !== 4'b1000) begin
            failures++;
            $display("FAIL reg_io_hold got=%b exp=1000", a_to_io);
        end
        tick();
        checks++;
        if (a_to_io !== 4'b0000) begin
            failures++;
            $display("FAIL reg_io_fall got=%b exp=0000", a_to_io);
        end
        $display("test_reg_io done");
    endtask

    task automatic test_out_of_range();
        logic [33:0] v;
        for (int s = 6; s <= 7; s++) begin
            v        = '0;
            v[14:12] = 3'(s);   // io0 select beyond the 6 tracks
            data_from_ic = 6'h00;
            load_cfg(v);
            data_from_ic = 6'h3F;
            #1;
            // io1..3 select track 0 (=1); io0 must read 0.
            checks++;
            if (a_to_io !== 4'b1110) begin
                failures++;
                $display("FAIL out_of_range sel=%0d got=%b exp=1110", s, a_to_io);
            end
        end
        data_from_ic = 6'h00;
        $display("test_out_of_range done");
    endtask

    task automatic test_reconfig_mid_op();
        logic [33:0] v;
        v        = '0;
        v[1:0]   = 2'd2;
        v[23:21] = 3'd5;
        v[33]    = 1'b1;
        data_from_io = 4'b0000;
        data_from_ic = 6'h00;
        load_cfg(v);
        data_from_io = 4'b0100;
        data_from_ic = 6'h20;
        repeat (3) tick();
        checks++;
        if (a_to_ic !== 6'b000001 || a_to_io !== 4'b1000) begin
            failures++;
            $display("FAIL reconfig_active got ic=%b io=%b exp ic=000001 io=1000", a_to_ic, a_to_io);
        end
        config_enable = 1'b1;
        config_in     = 1'b0;
        #1;
        checks++;
        if (a_to_ic !== 6'b000000) begin
            failures++;
            $display("FAIL reconfig_comb_now got=%b exp=000000", a_to_ic);
        end
        checks++;
        if (a_to_io !== 4'b1000) begin
            failures++;
            $display("FAIL reconfig_reg_hold got=%b exp=1000", a_to_io);
        end
        tick();
        checks++;
        if (a_to_io !== 4'b0000) begin
            failures++;
            $display("FAIL reconfig_reg_edge got=%b exp=0000", a_to_io);
        end
        config_enable = 1'b0;
        reset         = 1'b1;
        tick();
        reset = 1'b0;
        $display("test_reconfig_mid_op done");
    endtask

    task automatic test_chain();
        data_from_io  = 4'b0000;
        data_from_ic  = 6'h00;
        reset         = 1'b1;
        tick();
        reset         = 1'b0;
        config_enable = 1'b1;
        for (int k = 1; k <= 68; k++) begin
            config_in = (k == 1);
            tick();
            checks++;
            if (a_cfg_out !== (k == 34)) begin
                failures++;
                $display("FAIL chain_a_out edge=%0d got=%b exp=%b", k, a_cfg_out, (k == 34));
            end
            checks++;
            if (b_cfg_out !== (k == 68)) begin
                failures++;
                $display("FAIL chain_b_out edge=%0d got=%b exp=%b", k, b_cfg_out, (k == 68));
            end
        end
        config_enable = 1'b0;
        config_in     = 1'b0;
        #1;
        checks++;
        if (b_cfg_out !== 1'b1 || a_cfg_out !== 1'b0) begin
            failures++;
            $display("FAIL chain_final got a=%b b=%b exp a=0 b=1", a_cfg_out, b_cfg_out);
        end
        $display("test_chain done");
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        reset         = 1'b1;
        config_enable = 1'b0;
        config_in     = 1'b0;
        data_from_io  = 4'd0;
        data_from_ic  = 6'd0;
        test_reset();
        test_comb_ic();
        test_reg_io();
        test_out_of_range();
        test_reconfig_mid_op();
        test_chain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
